// File: rtl/ir_pkg.sv
// ir_pkg: NEC IR timing constants, FSM encoding and shared helpers for the IR transmit/receive path
package ir_pkg;
  localparam int unsigned CLK_DIV_DEF = 50;
  localparam int unsigned T_LEAD_MARK_DEF = 9000;
  localparam int unsigned T_LEAD_SPACE_DEF = 4500;
  localparam int unsigned T_BIT_MARK_DEF = 560;
  localparam int unsigned T_ZERO_SPACE_DEF = 560;
  localparam int unsigned T_ONE_SPACE_DEF = 1690;
  localparam int unsigned CARRIER_DIV = 1316;
  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned RX_LEAD_MIN = (T_LEAD_MARK_DEF * 3) / 4;
  localparam int unsigned RX_SPACE_MIN = (T_LEAD_SPACE_DEF * 3) / 4;
  localparam int unsigned RX_BIT_THRESH = (T_ZERO_SPACE_DEF + T_ONE_SPACE_DEF) / 2;
  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, DONE
  } state_e;
  function automatic logic is_mark(state_e s);
    return s == LEAD_MARK || s == BIT_MARK || s == STOP_MARK;
  endfunction
endpackage

// File: rtl/ir_tick_gen.sv
// ir_tick_gen: clearable prescaler; ports clk, rst, clr (restart count), tick (1-cycle pulse every CLK_DIV clocks)
module ir_tick_gen #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == W'(CLK_DIV - 1);
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ir_tx.sv
// ir_tx: NEC IR transmitter (lead, 32 pulse-distance bits MSB first, stop mark); ports clk, rst, i_start, i_data[31:0], o_ir_txb (active-low), o_busy, o_done; macro CARRIER_EN adds 38 kHz carrier on marks
module ir_tx
  import ir_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned T_LEAD_MARK = T_LEAD_MARK_DEF,
  parameter int unsigned T_LEAD_SPACE = T_LEAD_SPACE_DEF,
  parameter int unsigned T_BIT_MARK = T_BIT_MARK_DEF,
  parameter int unsigned T_ZERO_SPACE = T_ZERO_SPACE_DEF,
  parameter int unsigned T_ONE_SPACE = T_ONE_SPACE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_data,
  output logic        o_ir_txb,
  output logic        o_busy,
  output logic        o_done
);
  state_e state_q, state_d;
  logic [15:0] us_q, us_d, dur;
  logic [31:0] sh_q, sh_d;
  logic [5:0] cnt_q, cnt_d;
  logic ir_q, ir_d, busy_q, busy_d, done_q, done_d;
  logic tick, accept, phase_end, mark_d;
`ifdef CARRIER_EN
  logic [15:0] car_q, car_d;
`endif
  ir_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst(rst), .clr(accept), .tick(tick));
  always_comb begin
    accept = state_q == IDLE && i_start;
    dur = state_q == LEAD_MARK ? 16'(T_LEAD_MARK) :
          state_q == LEAD_SPACE ? 16'(T_LEAD_SPACE) :
          state_q == BIT_SPACE ? (sh_q[31] ? 16'(T_ONE_SPACE) : 16'(T_ZERO_SPACE)) :
          16'(T_BIT_MARK);
    phase_end = tick && us_q == dur - 16'd1;
    state_d = state_q;
    us_d = us_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    if (accept) begin
      state_d = LEAD_MARK;
      sh_d = i_data;
      cnt_d = '0;
      us_d = '0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q != IDLE && tick) begin
      us_d = phase_end ? '0 : us_q + 16'd1;
      if (phase_end) begin
        unique case (state_q)
          LEAD_MARK:  state_d = LEAD_SPACE;
          LEAD_SPACE: state_d = BIT_MARK;
          BIT_MARK:   state_d = BIT_SPACE;
          BIT_SPACE: begin
            sh_d = sh_q << 1;
            cnt_d = cnt_q + 6'd1;
            state_d = cnt_q == 6'(FRAME_BITS - 1) ? STOP_MARK : BIT_MARK;
          end
          STOP_MARK:  state_d = DONE;
          default:    state_d = IDLE;
        endcase
      end
    end
  end
  always_comb begin
    mark_d = is_mark(state_d);
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
`ifdef CARRIER_EN
    car_d = ((mark_d && state_d != state_q) || car_q == 16'(CARRIER_DIV - 1)) ? '0 : car_q + 16'd1;
    ir_d = !(mark_d && car_d < 16'(CARRIER_DIV / 2));
`else
    ir_d = !mark_d;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      us_q <= '0;
      sh_q <= '0;
      cnt_q <= '0;
      ir_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      us_q <= us_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      ir_q <= ir_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
`ifdef CARRIER_EN
  always_ff @(posedge clk) begin
    if (rst) car_q <= '0;
    else car_q <= car_d;
  end
`endif
  assign o_ir_txb = ir_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
endmodule
